// File: rtl/poly_mul_iter.sv
// Iterative redundant-coefficient polynomial multiplier: ColsPerCycle multiplier
// coefficients per cycle folded into a carry-save accumulator, with valid/ready handshakes.
module poly_mul_iter #(
  parameter int unsigned NumCoeffs    = 4,
  parameter int unsigned WordBits     = 16,
  parameter int unsigned ColsPerCycle = 1,
  parameter int unsigned ProdBits     = 2 * NumCoeffs * WordBits + 2,
  parameter int unsigned CpaBits      = 16,
  parameter int unsigned CpaCoeffs    = (ProdBits + CpaBits - 1) / CpaBits
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic                                 sqr_mode_i,
  input  logic [NumCoeffs*(WordBits+1)-1:0]    a_i,
  input  logic [NumCoeffs*(WordBits+1)-1:0]    b_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [ProdBits-1:0]                  product0_o,
  output logic [ProdBits-1:0]                  product1_o,
  output logic [CpaCoeffs*(CpaBits+1)-1:0]     cpa_product_o,
  output logic                                 busy_o
);

  localparam int unsigned CoefW  = WordBits + 1;
  localparam int unsigned OpW    = NumCoeffs * CoefW;
  localparam int unsigned Passes = (NumCoeffs + ColsPerCycle - 1) / ColsPerCycle;
  localparam int unsigned PassW  = (Passes > 1) ? $clog2(Passes) : 1;
  localparam int unsigned CpaW   = CpaCoeffs * CpaBits;
  localparam int unsigned CpaOutW = CpaCoeffs * (CpaBits + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [OpW-1:0]       a_q, a_d, b_q, b_d;
  logic [ProdBits-1:0]  acc0_q, acc0_d, acc1_q, acc1_d;
  logic [PassW-1:0]     pass_q, pass_d;
  logic [ProdBits-1:0]  prod0_q, prod0_d, prod1_q, prod1_d;
  logic [CpaOutW-1:0]   cpa_q, cpa_d;
  logic [ProdBits-1:0]  sum_s, sum_c;
  logic [CpaOutW-1:0]   cpa_next;
  logic                 accept, last_pass;

  function automatic logic [2*ProdBits-1:0] csa(input logic [ProdBits-1:0] x,
                                                input logic [ProdBits-1:0] y,
                                                input logic [ProdBits-1:0] z);
    logic [ProdBits-1:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    csa = {maj << 1, x ^ y ^ z};
  endfunction

  // 3:2 compressor chain: accumulator pair plus every partial-product row of this pass.
  // Each coefficient pair splits into low x low rows, the two top-bit rows and top x top.
  always_comb begin
    logic [ProdBits-1:0] s, c, row;
    logic [WordBits-1:0] al, bl;
    logic                ah, bh;
    logic [CoefW-1:0]    bcoef;
    int unsigned         j, sh;
    s     = acc0_q;
    c     = acc1_q;
    row   = '0;
    al    = '0;
    bl    = '0;
    ah    = 1'b0;
    bh    = 1'b0;
    bcoef = '0;
    j     = 0;
    sh    = 0;
    for (int unsigned jj = 0; jj < ColsPerCycle; jj++) begin
      j = 32'(pass_q) * ColsPerCycle + jj;
      if (j < NumCoeffs) begin
        bcoef = b_q[j*CoefW +: CoefW];
        bl    = bcoef[WordBits-1:0];
        bh    = bcoef[WordBits];
        for (int unsigned i = 0; i < NumCoeffs; i++) begin
          al = a_q[i*CoefW +: WordBits];
          ah = a_q[i*CoefW + WordBits];
          sh = (i + j) * WordBits;
          for (int unsigned k = 0; k < WordBits; k++) begin
            row    = bl[k] ? (ProdBits'(al) << (k + sh)) : '0;
            {c, s} = csa(s, c, row);
          end
          row    = ah ? (ProdBits'(bl) << (WordBits + sh)) : '0;
          {c, s} = csa(s, c, row);
          row    = bh ? (ProdBits'(al) << (WordBits + sh)) : '0;
          {c, s} = csa(s, c, row);
          row    = ProdBits'(ah & bh) << (2 * WordBits + sh);
          {c, s} = csa(s, c, row);
        end
      end
    end
    sum_s = s;
    sum_c = c;
  end

  always_comb begin
    logic [CpaW-1:0] x0, x1;
    x0       = CpaW'(sum_s);
    x1       = CpaW'(sum_c);
    cpa_next = '0;
    for (int unsigned k = 0; k < CpaCoeffs; k++) begin
      cpa_next[k*(CpaBits+1) +: CpaBits+1] = {1'b0, x0[k*CpaBits +: CpaBits]}
                                           + {1'b0, x1[k*CpaBits +: CpaBits]};
    end
  end

  assign last_pass = (pass_q == PassW'(Passes - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc0_d      = acc0_q;
    acc1_d      = acc1_q;
    pass_d      = pass_q;
    prod0_d     = prod0_q;
    prod1_d     = prod1_q;
    cpa_d       = cpa_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      IDLE: in_ready_o = 1'b1;
      RUN: begin
        busy_o = 1'b1;
        acc0_d = sum_s;
        acc1_d = sum_c;
        pass_d = pass_q + PassW'(1);
        if (last_pass) begin
          state_d = DONE;
          prod0_d = sum_s;
          prod1_d = sum_c;
          cpa_d   = cpa_next;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Acceptance overrides the DONE->IDLE exit so a handover goes straight to RUN.
    accept = in_ready_o & in_valid_i;
    if (accept) begin
      state_d = RUN;
      a_d     = a_i;
      b_d     = sqr_mode_i ? a_i : b_i;
      acc0_d  = '0;
      acc1_d  = '0;
      pass_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      pass_q  <= '0;
      prod0_q <= '0;
      prod1_q <= '0;
      cpa_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      pass_q  <= pass_d;
      prod0_q <= prod0_d;
      prod1_q <= prod1_d;
      cpa_q   <= cpa_d;
    end
  end

  assign product0_o    = prod0_q;
  assign product1_o    = prod1_q;
  assign cpa_product_o = cpa_q;

`ifndef SYNTHESIS
  function automatic logic [ProdBits-1:0] ref_product(input logic [OpW-1:0] x,
                                                      input logic [OpW-1:0] y);
    logic [ProdBits-1:0] vx, vy;
    vx = '0;
    vy = '0;
    for (int unsigned i = 0; i < NumCoeffs; i++) begin
      vx = vx + (ProdBits'(x[i*CoefW +: CoefW]) << (i * WordBits));
      vy = vy + (ProdBits'(y[i*CoefW +: CoefW]) << (i * WordBits));
    end
    return vx * vy;
  endfunction

  logic chk_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) chk_q <= 1'b0;
    else       chk_q <= (state_q == RUN) && (state_d == DONE);
    if (!rst_i && chk_q)
      assert (ProdBits'(prod0_q + prod1_q) == ref_product(a_q, b_q))
        else $error("poly_mul_iter: product does not equal a*b of latched operands");
  end
`endif

endmodule

// File: tb/tb_poly_mul_iter.sv
// Directed and randomized bench for poly_mul_iter at ColsPerCycle 1, 2 and 4.
module tb_poly_mul_iter;
  localparam int NC = 4;
  localparam int WB = 16;
  localparam int PB = 2 * NC * WB + 2;
  localparam int CB = 16;
  localparam int CC = (PB + CB - 1) / CB;
  localparam int NW = NC * (WB + 1);
  localparam int CW = CC * (CB + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NW-1:0] a, b;
  logic          sqr;
  logic          iv[3], ir[3], ov[3], ordy[3], bsy[3];
  logic [PB-1:0] p0[3], p1[3];
  logic [CW-1:0] cpa[3];

  int n_cmp = 0;
  int n_err = 0;

  poly_mul_iter #(.NumCoeffs(NC), .WordBits(WB), .ColsPerCycle(1), .CpaBits(CB)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[0]), .in_ready_o(ir[0]), .sqr_mode_i(sqr),
    .a_i(a), .b_i(b), .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .product0_o(p0[0]),
    .product1_o(p1[0]), .cpa_product_o(cpa[0]), .busy_o(bsy[0]));

  poly_mul_iter #(.NumCoeffs(NC), .WordBits(WB), .ColsPerCycle(2), .CpaBits(CB)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[1]), .in_ready_o(ir[1]), .sqr_mode_i(sqr),
    .a_i(a), .b_i(b), .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .product0_o(p0[1]),
    .product1_o(p1[1]), .cpa_product_o(cpa[1]), .busy_o(bsy[1]));

  poly_mul_iter #(.NumCoeffs(NC), .WordBits(WB), .ColsPerCycle(4), .CpaBits(CB)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[2]), .in_ready_o(ir[2]), .sqr_mode_i(sqr),
    .a_i(a), .b_i(b), .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .product0_o(p0[2]),
    .product1_o(p1[2]), .cpa_product_o(cpa[2]), .busy_o(bsy[2]));

  function automatic logic [PB-1:0] model(input logic [NW-1:0] x, input logic [NW-1:0] y);
    logic [PB-1:0] vx, vy;
    vx = '0;
    vy = '0;
    for (int i = 0; i < NC; i++) begin
      vx = vx + (PB'(x[i*(WB+1) +: WB+1]) << (i * WB));
      vy = vy + (PB'(y[i*(WB+1) +: WB+1]) << (i * WB));
    end
    return vx * vy;
  endfunction

  function automatic logic [PB-1:0] cpa_total(input logic [CW-1:0] c);
    logic [PB+CB:0] t;
    t = '0;
    for (int k = 0; k < CC; k++) t = t + ((PB+CB+1)'(c[k*(CB+1) +: CB+1]) << (k * CB));
    return t[PB-1:0];
  endfunction

  function automatic logic [NW-1:0] rnd_op();
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*(WB+1) +: WB+1] = (WB+1)'($urandom);
    if ($urandom_range(7) == 0) r = '1;
    return r;
  endfunction

  task automatic accept(input int d, input logic [NW-1:0] x, input logic [NW-1:0] y,
                        input logic s);
    int n;
    n = 0;
    a = x; b = y; sqr = s; iv[d] = 1'b1;
    while (!ir[d] && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 1;
    while (!ov[d] && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic pop(input int d);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; ordy[d] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ov[d] !== 1'b0 || bsy[d] !== 1'b0) begin
        n_err++; $display("FAIL reset_flags dut%0d: valid=%b busy=%b want 0 0", d, ov[d], bsy[d]);
      end
      n_cmp++;
      if (p0[d] !== '0 || p1[d] !== '0 || cpa[d] !== '0) begin
        n_err++; $display("FAIL reset_data dut%0d: p0=%h p1=%h cpa=%h want 0", d, p0[d], p1[d], cpa[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ir[d] !== 1'b1) begin n_err++; $display("FAIL reset_ready dut%0d: got %b want 1", d, ir[d]); end
    end
  endtask

  task automatic test_basic();
    int            lat;
    logic [PB-1:0] s;
    logic [CB:0]   c0;
    logic [CW-1:0] rest;
    accept(0, NW'(1), NW'(3), 1'b0);
    n_cmp++;
    if (bsy[0] !== 1'b1 || ir[0] !== 1'b0) begin
      n_err++; $display("FAIL basic_run: busy=%b ready=%b want 1 0", bsy[0], ir[0]);
    end
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 5) begin n_err++; $display("FAIL basic_latency: got %0d want 5", lat); end
    s = p0[0] + p1[0];
    n_cmp++;
    if (s !== PB'(3)) begin n_err++; $display("FAIL basic_sum: got %h want 3", s); end
    c0   = cpa[0][CB:0];
    rest = cpa[0] >> (CB + 1);
    n_cmp++;
    if (c0 !== (CB+1)'(3) || rest !== '0) begin
      n_err++; $display("FAIL basic_cpa: chunk0=%h upper=%h want 3 0", c0, rest);
    end
    pop(0);
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_err++; $display("FAIL basic_idle: valid=%b ready=%b want 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_all_ones();
    int            lat;
    int            want_lat[3];
    logic [NW-1:0] x;
    logic [PB-1:0] s, exp_p;
    want_lat[0] = 5; want_lat[1] = 3; want_lat[2] = 2;
    x = '1;
    exp_p = model(x, x);
    for (int d = 0; d < 3; d++) begin
      accept(d, x, x, 1'b0);
      wait_out(d, lat);
      n_cmp++;
      if (lat !== want_lat[d]) begin
        n_err++; $display("FAIL ones_latency dut%0d: got %0d want %0d", d, lat, want_lat[d]);
      end
      s = p0[d] + p1[d];
      n_cmp++;
      if (s !== exp_p) begin n_err++; $display("FAIL ones_sum dut%0d: got %h want %h", d, s, exp_p); end
      n_cmp++;
      if (cpa_total(cpa[d]) !== exp_p) begin
        n_err++; $display("FAIL ones_cpa dut%0d: got %h want %h", d, cpa_total(cpa[d]), exp_p);
      end
      pop(d);
    end
  endtask

  task automatic test_sqr();
    int            lat;
    logic [NW-1:0] x;
    logic [PB-1:0] s, exp_p;
    x = {17'h10DEF, 17'h09ABC, 17'h05678, 17'h01234};
    exp_p = model(x, x);
    accept(0, x, rnd_op(), 1'b1);
    wait_out(0, lat);
    s = p0[0] + p1[0];
    n_cmp++;
    if (s !== exp_p) begin n_err++; $display("FAIL sqr_sum: got %h want %h", s, exp_p); end
    n_cmp++;
    if (cpa_total(cpa[0]) !== exp_p) begin
      n_err++; $display("FAIL sqr_cpa: got %h want %h", cpa_total(cpa[0]), exp_p);
    end
    pop(0);
  endtask

  task automatic test_back_to_back();
    int            lat;
    logic [NW-1:0] x, y;
    logic [PB-1:0] s, exp_p;
    x = {17'h00007, 17'h1FFFF, 17'h0ABCD, 17'h10001};
    y = {17'h1FFFF, 17'h00000, 17'h12345, 17'h0FFFF};
    exp_p = model(x, y);
    accept(0, x, y, 1'b0);
    wait_out(0, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      s = p0[0] + p1[0];
      n_cmp++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || s !== exp_p || cpa_total(cpa[0]) !== exp_p) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: valid=%b ready=%b sum=%h want 1 0 %h", i, ov[0], ir[0], s, exp_p);
      end
    end
    x = {17'h1FFFF, 17'h00001, 17'h00002, 17'h00003};
    y = {17'h00000, 17'h10000, 17'h0FFFF, 17'h1FFFF};
    exp_p = model(x, y);
    a = x; b = y; sqr = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    n_cmp++;
    if (ir[0] !== 1'b1) begin n_err++; $display("FAIL handover_ready: got %b want 1", ir[0]); end
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      n_err++; $display("FAIL handover_state: valid=%b busy=%b want 0 1", ov[0], bsy[0]);
    end
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 5) begin n_err++; $display("FAIL handover_latency: got %0d want 5", lat); end
    s = p0[0] + p1[0];
    n_cmp++;
    if (s !== exp_p) begin n_err++; $display("FAIL handover_sum: got %h want %h", s, exp_p); end
    pop(0);
  endtask

  task automatic test_mid_reset();
    int            lat;
    logic [NW-1:0] x, y;
    logic [PB-1:0] s, exp_p;
    accept(0, rnd_op(), rnd_op(), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b0 || bsy[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_err++; $display("FAIL midreset_state: valid=%b busy=%b ready=%b want 0 0 1", ov[0], bsy[0], ir[0]);
    end
    n_cmp++;
    if (p0[0] !== '0 || p1[0] !== '0 || cpa[0] !== '0) begin
      n_err++; $display("FAIL midreset_data: p0=%h p1=%h cpa=%h want 0", p0[0], p1[0], cpa[0]);
    end
    x = {17'h0BEEF, 17'h1CAFE, 17'h00000, 17'h1FFFF};
    y = {17'h10000, 17'h00001, 17'h1F00F, 17'h0F0F0};
    exp_p = model(x, y);
    accept(0, x, y, 1'b0);
    wait_out(0, lat);
    s = p0[0] + p1[0];
    n_cmp++;
    if (lat !== 5 || s !== exp_p) begin
      n_err++; $display("FAIL midreset_fresh: lat=%0d sum=%h want 5 %h", lat, s, exp_p);
    end
    pop(0);
  endtask

  task automatic test_random_b2b();
    logic [PB-1:0] q[$];
    logic [PB-1:0] s, exp_p;
    logic [NW-1:0] x, y;
    logic          m, fire_in, fire_out;
    int            pushed, popped, cyc;
    pushed = 0; popped = 0; cyc = 0;
    x = '0; y = '0; m = 1'b0;
    while (popped < 1000 && cyc < 60000) begin
      if (!iv[0] && pushed < 1000 && $urandom_range(3) != 0) begin
        x = rnd_op(); y = rnd_op(); m = 1'($urandom_range(1));
        a = x; b = y; sqr = m; iv[0] = 1'b1;
      end
      ordy[0] = ($urandom_range(3) != 0);
      #1;
      fire_in  = iv[0] && ir[0];
      fire_out = ov[0] && ordy[0];
      if (fire_out) begin
        popped++;
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_extra: result %0d with nothing outstanding", popped);
        end else begin
          exp_p = q.pop_front();
          s = p0[0] + p1[0];
          if (s !== exp_p || cpa_total(cpa[0]) !== exp_p) begin
            n_err++;
            $display("FAIL rand_result %0d: sum=%h cpa=%h want %h", popped, s, cpa_total(cpa[0]), exp_p);
          end
        end
      end
      if (fire_in) begin
        q.push_back(model(x, m ? x : y));
        pushed++;
      end
      @(posedge clk); #1;
      if (fire_in) iv[0] = 1'b0;
      cyc++;
    end
    iv[0] = 1'b0; ordy[0] = 1'b0;
    n_cmp++;
    if (pushed !== 1000 || popped !== 1000 || q.size() !== 0) begin
      n_err++; $display("FAIL rand_count: pushed=%0d popped=%0d left=%0d want 1000 1000 0", pushed, popped, q.size());
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; sqr = 1'b0;
    for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; ordy[d] = 1'b0; end
    test_reset();
    test_basic();
    test_all_ones();
    test_sqr();
    test_back_to_back();
    test_mid_reset();
    test_random_b2b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
